dot_product_accumulator: RTL
============================

// Module: dot_product_accumulator
// PURPOSE
//  Sits directly downstream of array_multiplier and consumes its Z_final/o_valid stream.
//  Sums every VEC_LEN consecutive valid products into one dot-product result.
//  Buffers results in a small FIFO and presents them on a valid/ready output port.
//  The multiplier has no backpressure, so this block accepts a product on every cycle.
// PARAMETERS
//  DATAWIDTH    8                          operand width of the multiplier; a product is 2*DATAWIDTH bits
//  VEC_LEN      8                          number of products per result (>=1)
//  ACC_WIDTH    2*DATAWIDTH+$clog2(VEC_LEN) width of the accumulator and result (19 with the defaults)
//  FIFO_DEPTH   4                          number of result entries (power of 2, >=2)
//  INSTANCE_ID  0                          identifier only; no functional effect
// PORTS
//  clk         in   1                    clock, rising edge
//  rst         in   1                    asynchronous, active-low reset
//  i_valid     in   1                    i_product is valid this cycle (from multiplier o_valid)
//  i_product   in   2*DATAWIDTH          unsigned product (from multiplier Z_final)
//  i_clear     in   1                    synchronous flush of the accumulator, the FIFO and o_overflow
//  o_valid     out  1                    FIFO head holds a result
//  o_ready     in   1                    downstream accepts o_sum
//  o_sum       out  ACC_WIDTH            FIFO head result; 0 while o_valid=0
//  o_level     out  $clog2(FIFO_DEPTH)+1 number of FIFO entries occupied
//  o_busy      out  1                    a partial vector is in progress (elem_cnt != 0)
//  o_overflow  out  1                    sticky flag: a result was dropped because the FIFO was full
// BEHAVIOUR
//  Reset (rst=0, asynchronous):
//   - acc, elem_cnt, FIFO pointers, o_level and o_overflow are cleared to 0.
//   - All outputs are 0 immediately, without waiting for a clock edge.
//  Accumulation (edge with i_valid=1 and i_clear=0):
//   - sum_next = (elem_cnt==0 ? 0 : acc) + i_product; all arithmetic is unsigned.
//   - ACC_WIDTH guarantees the sum never wraps.
//   - If elem_cnt < VEC_LEN-1: acc <= sum_next; elem_cnt++.
//   - If elem_cnt == VEC_LEN-1: push sum_next to the FIFO; elem_cnt <= 0; acc <= 0.
//   - With VEC_LEN=1, every product is pushed directly.
//  Bubbles (i_valid=0): acc and elem_cnt hold their values; there is no timeout.
//  Latency: the final product is sampled at edge k.
//   - If the FIFO was empty, o_valid=1 and o_sum equal the result in the cycle after edge k.
//   - Otherwise the result queues behind the older entries, in order.
//  Output handshake:
//   - A pop occurs at an edge where o_valid && o_ready.
//   - o_sum stays stable while o_valid=1 and o_ready=0.
//   - o_ready is ignored while o_valid=0.
//  FIFO boundaries:
//   - Push and pop at the same edge: allowed at any level; o_level is unchanged.
//   - Push and pop at the same edge when full: accepted, no overflow.
//   - Push when full without a pop: the new result is discarded; stored entries are untouched; o_overflow <= 1.
//   - o_overflow stays set until reset or i_clear.
//   - Pointers wrap modulo FIFO_DEPTH.
//  i_clear (synchronous, highest priority):
//   - acc, elem_cnt, FIFO and o_overflow are cleared to 0 at the edge.
//   - A same-cycle i_valid product is discarded.
//   - A same-cycle pop does not take place.
//  Registers: acc, elem_cnt, FIFO storage, pointers and o_overflow.
//   - o_valid = (o_level != 0); o_busy is decoded from elem_cnt.
// TESTING
//  1. Defaults, o_ready=1, products 1..8 back-to-back -> one o_valid pulse, o_sum=36, in the cycle after the 8th product.
//  2. Eight products of 65025 -> o_sum=520200 (no wrap); o_busy=1 from product 1 until the push edge.
//  3. o_ready=0, five vectors of eight 1s -> o_level=4, o_overflow=1; then o_ready=1 -> four pops of 8; o_overflow stays 1.
//  4. FIFO full, o_ready=1 at the edge of the final product -> o_overflow=0, o_level stays 4, order preserved.
//  5. i_clear after 3 products (and with i_valid=1 that cycle), then eight products of 2 -> o_sum=16, o_level=1.
//  6. Bubbles between products (i_valid 1,0,0,1...) of 3 -> o_sum=24; async rst mid-vector with o_valid=1 -> all outputs 0 immediately.

Source files
------------

// File: rtl/dot_product_accumulator.sv
// dot_product_accumulator: sums every VEC_LEN valid products into one result and queues results in a FIFO
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   i_valid     i_product is valid this cycle
//   i_product   unsigned product from the multiplier
//   i_clear     synchronous flush of accumulator, FIFO and overflow flag
//   o_valid     FIFO head holds a result
//   o_ready     downstream accepts o_sum
//   o_sum       FIFO head result, 0 while empty
//   o_level     FIFO occupancy
//   o_busy      a partial vector is in progress
//   o_overflow  sticky: a result was dropped because the FIFO was full
module dot_product_accumulator #(
    parameter int DATAWIDTH   = 8,
    parameter int VEC_LEN     = 8,
    parameter int ACC_WIDTH   = 2*DATAWIDTH + $clog2(VEC_LEN),
    parameter int FIFO_DEPTH  = 4,
    parameter int INSTANCE_ID = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_valid,
    input  logic [2*DATAWIDTH-1:0]      i_product,
    input  logic                        i_clear,
    output logic                        o_valid,
    input  logic                        o_ready,
    output logic [ACC_WIDTH-1:0]        o_sum,
    output logic [$clog2(FIFO_DEPTH):0] o_level,
    output logic                        o_busy,
    output logic                        o_overflow
);
    localparam int CW = VEC_LEN > 1 ? $clog2(VEC_LEN) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [ACC_WIDTH-1:0] r_acc;
    logic [CW-1:0]        r_cnt;
    logic [ACC_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wp;
    logic [AW-1:0]        r_rp;
    logic [AW:0]          r_level;
    logic                 r_ovf;

    logic [ACC_WIDTH-1:0] w_sum;
    logic                 w_last;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_wr;

    always_comb begin
        w_sum  = (r_cnt == '0 ? '0 : r_acc) + ACC_WIDTH'(i_product);
        w_last = r_cnt == CW'(VEC_LEN - 1);
        w_push = i_valid && w_last;
        w_pop  = r_level != '0 && o_ready;
        w_full = r_level == (AW+1)'(FIFO_DEPTH);
        // a push into a full FIFO is only accepted when the head leaves at the same edge
        w_wr   = w_push && (!w_full || w_pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else if (i_clear) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (i_valid) begin
                r_acc <= w_last ? '0 : w_sum;
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end
            if (w_wr)
                r_wp <= r_wp + 1'b1;
            if (w_pop)
                r_rp <= r_rp + 1'b1;
            r_level <= r_level + (AW+1)'(w_wr) - (AW+1)'(w_pop);
            if (w_push && w_full && !w_pop)
                r_ovf <= 1'b1;
        end
    end

    // storage needs no reset: empty entries are never presented
    always_ff @(posedge clk) begin
        if (w_wr && !i_clear && rst)
            r_mem[r_wp] <= w_sum;
    end

    always_comb begin
        o_valid    = r_level != '0;
        o_sum      = o_valid ? r_mem[r_rp] : '0;
        o_level    = r_level;
        o_busy     = r_cnt != '0;
        o_overflow = r_ovf;
    end
endmodule
